// File: rtl/reg_file_mp.sv
// Multi-port integer register file for decode: two write ports, optional write->read bypass,
// per-register busy scoreboard and a sequential clear sweep that gates the ready signal.
module reg_file_mp #(
  parameter  int DATA_W = 32,
  parameter  int DEPTH  = 32,
  parameter  int NUM_RD = 2,
  parameter  int BYPASS = 1,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush_req,
  output logic                       ready,
  input  logic                       wb0_en,
  input  logic [ADDR_W-1:0]          wb0_addr,
  input  logic [DATA_W-1:0]          wb0_data,
  input  logic                       wb1_en,
  input  logic [ADDR_W-1:0]          wb1_addr,
  input  logic [DATA_W-1:0]          wb1_data,
  input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
  output logic [NUM_RD*DATA_W-1:0]   rd_data,
  output logic [NUM_RD-1:0]          rd_busy,
  input  logic                       busy_set_en,
  input  logic [ADDR_W-1:0]          busy_set_addr
);

  typedef enum logic {ST_CLEAR = 1'b0, ST_READY = 1'b1} state_e;

  localparam logic [ADDR_W-1:0] ADDR_ZERO = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);

  state_e                   state_q;
  logic [ADDR_W-1:0]        clr_idx_q;
  logic                     ready_q;
  logic [DATA_W-1:0]        regs_q [DEPTH];
  logic [DEPTH-1:0]         busy_q;
  logic [DEPTH-1:0]         busy_d;
  logic                     run_s;
  logic                     wr0_s;
  logic                     wr1_s;
  logic                     set_s;
  logic [ADDR_W-1:0]        ra_s [NUM_RD];
  logic [NUM_RD*DATA_W-1:0] rd_data_s;
  logic [NUM_RD-1:0]        rd_busy_s;

  // A flush cycle drops every write and busy update presented alongside it.
  assign run_s = (state_q == ST_READY) && !flush_req;
  assign wr0_s = run_s && wb0_en && (wb0_addr != ADDR_ZERO);
  assign wr1_s = run_s && wb1_en && (wb1_addr != ADDR_ZERO);
  assign set_s = run_s && busy_set_en && (busy_set_addr != ADDR_ZERO);

  // Clear/ready sequencer: sweeps every index once, then holds READY until a flush.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_CLEAR;
      clr_idx_q <= ADDR_ZERO;
      ready_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_CLEAR: begin
          clr_idx_q <= clr_idx_q + ADDR_ONE;
          if (clr_idx_q == ADDR_LAST) begin
            state_q <= ST_READY;
            ready_q <= 1'b1;
          end
        end
        ST_READY: begin
          if (flush_req) begin
            state_q   <= ST_CLEAR;
            clr_idx_q <= ADDR_ZERO;
            ready_q   <= 1'b0;
          end
        end
        default: begin
          state_q   <= ST_CLEAR;
          clr_idx_q <= ADDR_ZERO;
          ready_q   <= 1'b0;
        end
      endcase
    end
  end

  // Storage has no reset; the sweep is the only thing that zeroes it. wb1 is written last so it wins.
  always_ff @(posedge clk) begin
    if (state_q == ST_CLEAR) begin
      regs_q[clr_idx_q] <= '0;
    end else begin
      if (wr0_s) regs_q[wb0_addr] <= wb0_data;
      if (wr1_s) regs_q[wb1_addr] <= wb1_data;
    end
  end

  // Scoreboard next state: writes retire a producer, a same-cycle issue to that register re-arms it.
  always_comb begin
    busy_d = busy_q;
    if (state_q == ST_READY) begin
      if (flush_req) begin
        busy_d = '0;
      end else begin
        if (wr0_s) busy_d[wb0_addr] = 1'b0;
        if (wr1_s) busy_d[wb1_addr] = 1'b0;
        if (set_s) busy_d[busy_set_addr] = 1'b1;
      end
    end else begin
      busy_d = '0;
    end
    busy_d[0] = 1'b0;
  end

  // Scoreboard register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  for (genvar g = 0; g < NUM_RD; g++) begin : g_rd_addr
    assign ra_s[g] = rd_addr[g*ADDR_W +: ADDR_W];
  end

  // Combinational read ports with optional forwarding of accepted writes.
  always_comb begin
    rd_data_s = '0;
    rd_busy_s = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      if ((state_q == ST_READY) && (ra_s[i] != ADDR_ZERO)) begin
        rd_busy_s[i] = busy_q[ra_s[i]];
        if ((BYPASS != 0) && wr1_s && (wb1_addr == ra_s[i])) begin
          rd_data_s[i*DATA_W +: DATA_W] = wb1_data;
        end else if ((BYPASS != 0) && wr0_s && (wb0_addr == ra_s[i])) begin
          rd_data_s[i*DATA_W +: DATA_W] = wb0_data;
        end else begin
          rd_data_s[i*DATA_W +: DATA_W] = regs_q[ra_s[i]];
        end
      end else begin
        rd_busy_s[i] = 1'b0;
      end
    end
  end

  assign rd_data = rd_data_s;
  assign rd_busy = rd_busy_s;
  assign ready   = ready_q;

endmodule
